exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Latches the decoded bundle from ID and computes the ALU result, or runs an iterative 32-cycle divider for div/mod instructions.
- Drives the synchronous data-SRAM request for loads and stores (address, byte enables, lane-replicated write data).
- Forwards the in-flight result and a blocking flag back to ID for bypass and stall decisions.

Parameters:
- none; bus widths fixed: DS_TO_ES_BUS_WD=158, ES_TO_MS_BUS_WD=75, ES_FORWARD_WD=40

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_allowin  in  1  MEM can accept
- es_allowin  out  1  EXE can accept
- ds_to_es_valid  in  1  ID bundle valid
- ds_to_es_bus  in  158  {alu_op[11:0] 157:146, div_op[3:0] 145:142, load_op[4:0] 141:137, store_op[2:0] 136:134, gr_we 133, dest[4:0] 132:128, src1 127:96, src2 95:64, st_data 63:32, pc 31:0}
- es_to_ms_valid  out  1  bundle to MEM valid
- es_to_ms_bus  out  75  {load_op[4:0] 74:70, gr_we 69, dest 68:64, es_result 63:32, pc 31:0}
- data_sram_en  out  1  SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  write data
- es_forward  out  40  {es_valid 39, es_blocking 38, gr_we 37, dest 36:32, es_result 31:0}

Behaviour:
- Bundle register loads on ds_to_es_valid && es_allowin. es_valid: reset→0; loads ds_to_es_valid when es_allowin.
- es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
- alu_op is one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0].
  - lui returns src2.
  - slt/sltu return {31'b0, flag}.
  - All-zero alu_op → result 0.
- Loads and stores always carry alu_op=add; address = src1+src2.
- div_op is one-hot: div.w, mod.w, div.wu, mod.wu. Divider FSM:
  - IDLE: on es_valid && div_op!=0, latch |src1|, |src2| (signed ops) or raw operands (unsigned ops) and the signs; cnt←0; →BUSY.
  - BUSY: one restoring iteration per cycle; after 32 iterations →DONE.
  - DONE: es_ready_go=1; on es_ready_go && ms_allowin →IDLE.
  - Latency: first valid cycle T, ready_go at T+33.
  - Signed fix-up: quotient negated if signs differ; remainder takes dividend sign.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = src1, for all four ops.
  - 0x80000000 / -1 (div.w): quotient 0x80000000; mod.w remainder 0.
- es_ready_go = 1 for non-div bundles; 1 only in DONE for div.
- es_result = quotient or remainder per div_op, else ALU result.
- es_blocking = es_valid && (load_op!=0 || (div_op!=0 && !es_ready_go)).
- SRAM request fires only on handoff: data_sram_en = es_valid && es_ready_go && ms_allowin && (load_op!=0 || store_op!=0). A stalled MEM therefore never loses load data.
- Byte enables, store_op one-hot (st.w, st.h, st.b):
  - st.w: we=4'b1111, wdata=st_data.
  - st.h: we=4'b0011 or 4'b1100 by addr[1]; wdata={2{st_data[15:0]}}.
  - st.b: we=4'b0001<<addr[1:0]; wdata={4{st_data[7:0]}}.
  - Loads: we=0.
- data_sram_addr = ALU sum (unaligned addresses are passed through unchecked).
- Reset mid-divide: es_valid=0 and FSM→IDLE next cycle; no SRAM request issued.
- A new bundle cannot enter during BUSY/DONE because es_allowin=0.
- Outputs after reset: es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, es_forward[39]=0, es_allowin=1.

Test Plan:
- add src1=0x7FFFFFFF src2=1, ms_allowin=1 → next cycle es_to_ms_valid=1, es_result=0x80000000, ready_go=1.
- st.b with src1=0x1000, src2=3, st_data=0x000000AB → single-cycle en=1, we=4'b1000, addr=0x1003, wdata=0xABABABAB.
- ld.w with ms_allowin=0 for 3 cycles → en=0 and es_blocking=1 while stalled; en=1 exactly in the handoff cycle.
- div.w src1=-7, src2=2 → ready_go low T..T+32, high at T+33, result 0xFFFFFFFD; mod.w same operands → 0xFFFFFFFF.
- div.wu src1=5, src2=0 → 0xFFFFFFFF; mod.wu → 5; div.w 0x80000000/0xFFFFFFFF → 0x80000000.
- reset asserted at T+10 of a divide → next cycle es_valid=0, FSM IDLE; a following add completes in 1 cycle.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage in-order pipeline.
// Holds the decoded bundle from ID, computes the ALU result or runs a
// 32-iteration restoring divider, issues the data-SRAM request on handoff
// to MEM, and forwards the in-flight result and a stall flag back to ID.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [157:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [74:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [39:0]  es_forward
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Pipeline register
    logic         r_es_valid;
    logic [157:0] r_ds_to_es_bus;

    // Divider state
    div_state_t   r_div_state;
    logic [4:0]   r_div_cnt;
    logic [31:0]  r_div_quot;     // dividend shifts out, quotient bits shift in
    logic [31:0]  r_div_rem;
    logic [31:0]  r_div_dsor;
    logic         r_div_neg_q;
    logic         r_div_neg_r;
    logic         r_div_by_zero;

    // Bundle fields
    logic [11:0]  w_alu_op;
    logic [3:0]   w_div_op;
    logic [4:0]   w_load_op;
    logic [2:0]   w_store_op;
    logic         w_gr_we;
    logic [4:0]   w_dest;
    logic [31:0]  w_src1;
    logic [31:0]  w_src2;
    logic [31:0]  w_st_data;
    logic [31:0]  w_pc;

    logic [31:0]  w_add_result;
    logic [31:0]  w_alu_result;
    logic [31:0]  w_es_result;
    logic         w_is_div;
    logic         w_div_signed;
    logic         w_es_ready_go;
    logic         w_es_blocking;
    logic         w_is_mem;

    logic [32:0]  w_div_shift;
    logic [31:0]  w_div_diff;
    logic         w_div_fits;
    logic [31:0]  w_div_q;
    logic [31:0]  w_div_r;

    assign {w_alu_op, w_div_op, w_load_op, w_store_op, w_gr_we,
            w_dest, w_src1, w_src2, w_st_data, w_pc} = r_ds_to_es_bus;

    assign w_is_div      = (w_div_op != 4'd0);
    assign w_div_signed  = w_div_op[0] | w_div_op[1];
    assign w_is_mem      = (w_load_op != 5'd0) || (w_store_op != 3'd0);
    assign w_es_ready_go = w_is_div ? (r_div_state == DIV_DONE) : 1'b1;
    assign w_es_blocking = r_es_valid &&
                           ((w_load_op != 5'd0) || (w_is_div && !w_es_ready_go));

    assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_es_ready_go;

    // Bundle register and its valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid     <= 1'b0;
            r_ds_to_es_bus <= 158'd0;
        end else begin
            if (es_allowin) begin
                r_es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                r_ds_to_es_bus <= ds_to_es_bus;
            end
        end
    end

    assign w_add_result = w_src1 + w_src2;

    // One-hot ALU; an empty or malformed op yields zero
    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_op)
            12'b0000_0000_0001: w_alu_result = w_add_result;
            12'b0000_0000_0010: w_alu_result = w_src1 - w_src2;
            12'b0000_0000_0100: w_alu_result = {31'd0, $signed(w_src1) < $signed(w_src2)};
            12'b0000_0000_1000: w_alu_result = {31'd0, w_src1 < w_src2};
            12'b0000_0001_0000: w_alu_result = w_src1 & w_src2;
            12'b0000_0010_0000: w_alu_result = ~(w_src1 | w_src2);
            12'b0000_0100_0000: w_alu_result = w_src1 | w_src2;
            12'b0000_1000_0000: w_alu_result = w_src1 ^ w_src2;
            12'b0001_0000_0000: w_alu_result = w_src1 << w_src2[4:0];
            12'b0010_0000_0000: w_alu_result = w_src1 >> w_src2[4:0];
            12'b0100_0000_0000: w_alu_result = $signed(w_src1) >>> w_src2[4:0];
            12'b1000_0000_0000: w_alu_result = w_src2;
            default:            w_alu_result = 32'd0;
        endcase
    end

    // Restoring step: the 33-bit trial compare decides the quotient bit;
    // when it fits, the difference is below the divisor so 32 bits suffice.
    assign w_div_shift = {r_div_rem, r_div_quot[31]};
    assign w_div_fits  = (w_div_shift >= {1'b0, r_div_dsor});
    assign w_div_diff  = w_div_shift[31:0] - r_div_dsor;

    // Divider sequencing: latch magnitudes, iterate 32 times, hold until MEM takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_state   <= DIV_IDLE;
            r_div_cnt     <= 5'd0;
            r_div_quot    <= 32'd0;
            r_div_rem     <= 32'd0;
            r_div_dsor    <= 32'd0;
            r_div_neg_q   <= 1'b0;
            r_div_neg_r   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_div_state)
                DIV_IDLE: begin
                    if (r_es_valid && w_is_div) begin
                        r_div_quot    <= (w_div_signed && w_src1[31]) ? (32'd0 - w_src1) : w_src1;
                        r_div_dsor    <= (w_div_signed && w_src2[31]) ? (32'd0 - w_src2) : w_src2;
                        r_div_rem     <= 32'd0;
                        r_div_neg_q   <= w_div_signed && (w_src1[31] ^ w_src2[31]);
                        r_div_neg_r   <= w_div_signed && w_src1[31];
                        r_div_by_zero <= (w_src2 == 32'd0);
                        r_div_cnt     <= 5'd0;
                        r_div_state   <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    r_div_rem  <= w_div_fits ? w_div_diff : w_div_shift[31:0];
                    r_div_quot <= {r_div_quot[30:0], w_div_fits};
                    r_div_cnt  <= r_div_cnt + 5'd1;
                    if (r_div_cnt == 5'd31) begin
                        r_div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (w_es_ready_go && ms_allowin) begin
                        r_div_state <= DIV_IDLE;
                    end
                end
                default: begin
                    r_div_state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Sign fix-up; divide-by-zero overrides give all-ones quotient and the raw dividend
    assign w_div_q = r_div_by_zero ? 32'hFFFF_FFFF :
                     (r_div_neg_q ? (32'd0 - r_div_quot) : r_div_quot);
    assign w_div_r = r_div_by_zero ? w_src1 :
                     (r_div_neg_r ? (32'd0 - r_div_rem) : r_div_rem);

    // Select divider quotient, remainder or ALU result
    always_comb begin
        w_es_result = w_alu_result;
        if (w_div_op[0] || w_div_op[2]) begin
            w_es_result = w_div_q;
        end else if (w_div_op[1] || w_div_op[3]) begin
            w_es_result = w_div_r;
        end else begin
            w_es_result = w_alu_result;
        end
    end

    assign es_to_ms_bus = {w_load_op, w_gr_we, w_dest, w_es_result, w_pc};
    assign es_forward   = {r_es_valid, w_es_blocking, w_gr_we, w_dest, w_es_result};

    // The request goes out only in the cycle MEM accepts the bundle
    assign data_sram_en   = r_es_valid && w_es_ready_go && ms_allowin && w_is_mem;
    assign data_sram_addr = w_add_result;

    // Byte enables and lane-replicated write data per store width
    always_comb begin
        data_sram_we    = 4'b0000;
        data_sram_wdata = w_st_data;
        case (w_store_op)
            3'b001: begin
                data_sram_we    = 4'b1111;
                data_sram_wdata = w_st_data;
            end
            3'b010: begin
                data_sram_we    = w_add_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{w_st_data[15:0]}};
            end
            3'b100: begin
                data_sram_we    = 4'b0001 << w_add_result[1:0];
                data_sram_wdata = {4{w_st_data[7:0]}};
            end
            default: begin
                data_sram_we    = 4'b0000;
                data_sram_wdata = w_st_data;
            end
        endcase
    end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage with a behavioural reference model.
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [157:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [74:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [39:0]  es_forward;

    int n_checks = 0;
    int n_errors = 0;

    localparam int K_ADD = 0,  K_SUB = 1,  K_SLT = 2,  K_SLTU = 3;
    localparam int K_AND = 4,  K_NOR = 5,  K_OR = 6,   K_XOR = 7;
    localparam int K_SLL = 8,  K_SRL = 9,  K_SRA = 10, K_LUI = 11;
    localparam int K_NONE = 12, K_LD = 13, K_STW = 14, K_STH = 15, K_STB = 16;
    localparam int K_DIVW = 17, K_MODW = 18, K_DIVWU = 19, K_MODWU = 20;

    always #5 clk = ~clk;

    exe_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_forward      (es_forward)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [157:0] mk(input int kind, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] sd, input logic [31:0] pc,
                                        input logic [4:0] dest, input logic [4:0] ld);
        logic [11:0] alu;
        logic [3:0]  dv;
        logic [4:0]  lo;
        logic [2:0]  so;
        logic        gw;
        alu = 12'd0; dv = 4'd0; lo = 5'd0; so = 3'd0; gw = 1'b1;
        if (kind <= K_LUI) alu = 12'd1 << kind;
        else if (kind >= K_LD && kind <= K_STB) alu = 12'd1;
        if (kind == K_LD) lo = ld;
        if (kind >= K_STW && kind <= K_STB) begin
            so = 3'd1 << (kind - K_STW);
            gw = 1'b0;
        end
        if (kind >= K_DIVW) dv = 4'd1 << (kind - K_DIVW);
        return {alu, dv, lo, so, gw, dest, s1, s2, sd, pc};
    endfunction

    // Architectural result of each operation, straight from the ISA rules
    function automatic logic [31:0] model(input int kind, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (kind)
            K_ADD, K_LD, K_STW, K_STH, K_STB: return a + b;
            K_SUB:  return a - b;
            K_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            K_SLTU: return (a < b) ? 32'd1 : 32'd0;
            K_AND:  return a & b;
            K_NOR:  return ~(a | b);
            K_OR:   return a | b;
            K_XOR:  return a ^ b;
            K_SLL:  return a << b[4:0];
            K_SRL:  return a >> b[4:0];
            K_SRA:  return sa >>> b[4:0];
            K_LUI:  return b;
            K_DIVW: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            K_MODW: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            K_DIVWU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            K_MODWU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Send one bundle, hold MEM off for `stall` cycles after it is ready, check every cycle
    task automatic run_txn(input int kind, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] sd, input int stall);
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [4:0]  ld;
        logic [31:0] exp_res;
        logic [31:0] addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        bit is_div, is_ld, is_st, done, exp_go;
        int ready_k;
        pc      = $urandom;
        dest    = 5'($urandom);
        ld      = 5'd1 << $urandom_range(0, 4);
        is_div  = (kind >= K_DIVW);
        is_ld   = (kind == K_LD);
        is_st   = (kind >= K_STW && kind <= K_STB);
        ready_k = is_div ? 33 : 0;
        exp_res = model(kind, s1, s2);
        addr    = s1 + s2;
        exp_we  = 4'b0000;
        exp_wd  = sd;
        if (kind == K_STW) begin
            exp_we = 4'b1111;
        end else if (kind == K_STH) begin
            exp_we = addr[1] ? 4'b1100 : 4'b0011;
            exp_wd = {sd[15:0], sd[15:0]};
        end else if (kind == K_STB) begin
            exp_we = 4'b0001 << addr[1:0];
            exp_wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        end
        done = 1'b0;

        @(posedge clk); #1;
        chk("allowin_idle", {31'd0, es_allowin}, 32'd1);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(kind, s1, s2, sd, pc, dest, ld);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};

        for (int k = 0; k < 100 && !done; k++) begin
            ms_allowin = (k >= ready_k + stall);
            @(negedge clk);
            exp_go = (k >= ready_k);
            chk("to_ms_valid", {31'd0, es_to_ms_valid}, {31'd0, exp_go});
            chk("blocking", {31'd0, es_forward[38]}, {31'd0, is_ld || (is_div && !exp_go)});
            chk("allowin", {31'd0, es_allowin}, {31'd0, exp_go && ms_allowin});
            chk("sram_en", {31'd0, data_sram_en}, {31'd0, (is_ld || is_st) && exp_go && ms_allowin});
            if (es_to_ms_valid && ms_allowin) begin
                done = 1'b1;
                chk("result", es_to_ms_bus[63:32], exp_res);
                chk("pc", es_to_ms_bus[31:0], pc);
                chk("dest", {27'd0, es_to_ms_bus[68:64]}, {27'd0, dest});
                chk("gr_we", {31'd0, es_to_ms_bus[69]}, {31'd0, !is_st});
                chk("load_op", {27'd0, es_to_ms_bus[74:70]}, is_ld ? {27'd0, ld} : 32'd0);
                chk("fwd_result", es_forward[31:0], exp_res);
                chk("fwd_valid", {31'd0, es_forward[39]}, 32'd1);
                chk("fwd_dest", {27'd0, es_forward[36:32]}, {27'd0, dest});
                if (is_ld || is_st) begin
                    chk("sram_addr", data_sram_addr, addr);
                    chk("sram_we", {28'd0, data_sram_we}, {28'd0, exp_we});
                    if (is_st) chk("sram_wdata", data_sram_wdata, exp_wd);
                end
            end
            @(posedge clk); #1;
        end
        if (!done) chk("handoff_timeout", 32'd0, 32'd1);
        ms_allowin = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = 158'd0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        chk("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
        chk("rst_sram_we", {28'd0, data_sram_we}, 32'd0);
        chk("rst_fwd_valid", {31'd0, es_forward[39]}, 32'd0);
        chk("rst_allowin", {31'd0, es_allowin}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        run_txn(K_ADD,   32'h7FFF_FFFF, 32'd1, 32'd0, 0);
        run_txn(K_STB,   32'h0000_1000, 32'd3, 32'h0000_00AB, 0);
        run_txn(K_LD,    32'h0000_2000, 32'd4, 32'd0, 3);
        run_txn(K_STH,   32'h0000_3000, 32'd2, 32'h1234_5678, 1);
        run_txn(K_STW,   32'h0000_3000, 32'd8, 32'hDEAD_BEEF, 0);
        run_txn(K_DIVW,  32'hFFFF_FFF9, 32'd2, 32'd0, 0);
        run_txn(K_MODW,  32'hFFFF_FFF9, 32'd2, 32'd0, 2);
        run_txn(K_DIVWU, 32'd5, 32'd0, 32'd0, 0);
        run_txn(K_MODWU, 32'd5, 32'd0, 32'd0, 0);
        run_txn(K_DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_txn(K_MODW,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_txn(K_MODW,  32'hFFFF_FFF9, 32'd0, 32'd0, 0);
        run_txn(K_NONE,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0);
        run_txn(K_SRA,   32'h8000_0000, 32'd31, 32'd0, 0);

        // Reset in the middle of a divide
        @(posedge clk); #1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(K_DIVW, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h100, 5'd3, 5'd0);
        ms_allowin     = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_fwd_valid", {31'd0, es_forward[39]}, 32'd0);
        chk("midrst_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        chk("midrst_sram_en", {31'd0, data_sram_en}, 32'd0);
        chk("midrst_allowin", {31'd0, es_allowin}, 32'd1);
        ms_allowin = 1'b0;
        run_txn(K_ADD,  32'd10, 32'd20, 32'd0, 0);
        run_txn(K_DIVW, 32'd100, 32'hFFFF_FFFD, 32'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(0, 20), pick(), pick(), $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
